mux_scan_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 2:1 mux and drives its select line S. It then consumes the mux output X. On each START it selects input A, waits for the path to settle, and majority-samples X. It repeats the same for input B, then reports both channel results with a one-cycle DONE pulse.

---
 rtl/mux_scan_ctrl_if.sv | 20 ++
 rtl/mux_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_if.sv
// Handshake and mux-feedback bundle between the scan sequencer and its user/mux.
// Carries GLITCH only when MUX_SCAN_GLITCH_EN is defined.
interface mux_scan_ctrl_if;
  logic START;
  logic X;
  logic S;
  logic BUSY;
  logic DONE;
  logic RA;
  logic RB;
`ifdef MUX_SCAN_GLITCH_EN
  logic GLITCH;

  modport master (output START, X, input S, BUSY, DONE, RA, RB, GLITCH);
  modport slave  (input START, X, output S, BUSY, DONE, RA, RB, GLITCH);
`else
  modport master (output START, X, input S, BUSY, DONE, RA, RB);
  modport slave  (input START, X, output S, BUSY, DONE, RA, RB);
`endif
endinterface

// File: rtl/mux_scan_ctrl.sv
// Drives a 2:1 mux select, settles, majority-samples A then B, and pulses DONE.
// Optional sticky sample-disagreement flag GLITCH under MUX_SCAN_GLITCH_EN.
module mux_scan_ctrl #(
  parameter int SETTLE  = 2,
  parameter int SAMPLES = 3
) (
  input  logic          CLK,
  input  logic          RST,
  mux_scan_ctrl_if.slave bus
);

  localparam int MAX_CNT = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE_A,
    SAMPLE_A,
    SETTLE_B,
    SAMPLE_B
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ones_q, ones_d;
  logic [CW-1:0] ones_total;
  logic          s_q, s_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ra_q, ra_d;
  logic          rb_q, rb_d;
  logic          vote;
  logic          disagree;
`ifdef MUX_SCAN_GLITCH_EN
  logic          glitch_q, glitch_d;
`endif

  // The final sample edge must count the X present on that same edge.
  assign ones_total = ones_q + CW'(bus.X);
  assign vote       = (2 * int'(ones_total)) > SAMPLES;
  assign disagree   = (ones_total != '0) && (int'(ones_total) < SAMPLES);

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    s_d     = s_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ra_d    = ra_q;
    rb_d    = rb_q;
`ifdef MUX_SCAN_GLITCH_EN
    glitch_d = glitch_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          s_d     = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          ones_d  = '0;
          state_d = SETTLE_A;
`ifdef MUX_SCAN_GLITCH_EN
          glitch_d = 1'b0;
`endif
        end
      end

      SETTLE_A, SETTLE_B: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          cnt_d   = '0;
          ones_d  = '0;
          state_d = (state_q == SETTLE_A) ? SAMPLE_A : SAMPLE_B;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SAMPLE_A, SAMPLE_B: begin
        if (cnt_q == CW'(SAMPLES - 1)) begin
          cnt_d  = '0;
          ones_d = '0;
          if (state_q == SAMPLE_A) begin
            ra_d    = vote;
            s_d     = 1'b1;
            state_d = SETTLE_B;
          end else begin
            rb_d    = vote;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
`ifdef MUX_SCAN_GLITCH_EN
          if (disagree) glitch_d = 1'b1;
`endif
        end else begin
          cnt_d  = cnt_q + 1'b1;
          ones_d = ones_total;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ones_q  <= '0;
      s_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ra_q    <= 1'b0;
      rb_q    <= 1'b0;
`ifdef MUX_SCAN_GLITCH_EN
      glitch_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
`ifdef MUX_SCAN_GLITCH_EN
      glitch_q <= glitch_d;
`endif
    end
  end

  assign bus.S    = s_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.RA   = ra_q;
  assign bus.RB   = rb_q;
`ifdef MUX_SCAN_GLITCH_EN
  assign bus.GLITCH = glitch_q;
`else
  // disagree only feeds the optional flag
  logic unused_disagree;
  assign unused_disagree = disagree;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with default SETTLE=2, SAMPLES=3.
// GLITCH checks are compiled in only with MUX_SCAN_GLITCH_EN.
module tb_mux_scan_ctrl;

  logic CLK = 1'b0;
  logic RST;
  logic use_model;
  logic a_val, b_val, x_dir;
  int   n_pass  = 0;
  int   n_total = 0;

  mux_scan_ctrl_if bus ();

  mux_scan_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Mux model: X follows the selected input, or a directly driven value.
  assign bus.X = use_model ? (bus.S ? b_val : a_val) : x_dir;

  logic [4:0] outs;
  assign outs = {bus.S, bus.BUSY, bus.DONE, bus.RA, bus.RB};

  typedef struct {
    logic       start;
    logic [4:0] exp;   // {S, BUSY, DONE, RA, RB}
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Runs one scan from IDLE with A-phase X samples taken from pat (bit 0 first).
  task automatic scan_direct(input logic [2:0] pat, input string tag);
    for (int e = 0; e <= 10; e++) begin
      bus.START = (e == 0);
      x_dir     = (e >= 3 && e <= 5) ? pat[e-3] : 1'b0;
      step();
`ifdef MUX_SCAN_GLITCH_EN
      if (e == 0) check({tag, "_glitch_clr"}, bus.GLITCH, 0);
`endif
    end
    bus.START = 1'b0;
    check({tag, "_done"}, bus.DONE, 1);
  endtask

  initial begin
    // Test 1: reset with START high and X toggling
    RST = 1'b1; bus.START = 1'b1; use_model = 1'b0; x_dir = 1'b0;
    a_val = 1'b0; b_val = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x_dir = ~x_dir;
      step();
      check($sformatf("t1_rst%0d", i), outs, 5'b00000);
`ifdef MUX_SCAN_GLITCH_EN
      check($sformatf("t1_glitch%0d", i), bus.GLITCH, 0);
`endif
    end
    RST = 1'b0; bus.START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t1_idle%0d", i), outs, 5'b00000);
    end

    // Test 2: single scan through the mux model, A=1 B=0
    vecs[0] = '{1'b1, 5'b01000};
    for (int i = 1; i <= 4; i++) vecs[i] = '{1'b0, 5'b01000};
    for (int i = 5; i <= 9; i++) vecs[i] = '{1'b0, 5'b11010};
    vecs[10] = '{1'b0, 5'b10110};
    vecs[11] = '{1'b0, 5'b10010};
    use_model = 1'b1; a_val = 1'b1; b_val = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.START = vecs[i].start;
      step();
      check($sformatf("t2_edge%0d", i), outs, vecs[i].exp);
    end
    bus.START = 1'b0;

    // Test 3: direct X patterns during SAMPLE_A
    use_model = 1'b0;
    scan_direct(3'b101, "t3a");
    check("t3a_ra", bus.RA, 1);
`ifdef MUX_SCAN_GLITCH_EN
    check("t3a_glitch", bus.GLITCH, 1);
`endif
    step();
    scan_direct(3'b010, "t3b");
    check("t3b_ra", bus.RA, 0);
`ifdef MUX_SCAN_GLITCH_EN
    check("t3b_glitch", bus.GLITCH, 1);
`endif
    step();
    scan_direct(3'b111, "t3c");
    check("t3c_ra", bus.RA, 1);
`ifdef MUX_SCAN_GLITCH_EN
    check("t3c_glitch", bus.GLITCH, 0);
`endif
    step();

    // Test 4: START held, back-to-back scans with period 11
    use_model = 1'b1; a_val = 1'b0; b_val = 1'b1;
    bus.START = 1'b1;
    for (int e = 0; e <= 32; e++) begin
      step();
      check($sformatf("t4_done%0d", e), bus.DONE, ((e % 11) == 10));
      check($sformatf("t4_busy%0d", e), bus.BUSY, ((e % 11) != 10));
      if ((e % 11) == 10) begin
        check($sformatf("t4_ra%0d", e), bus.RA, 0);
        check($sformatf("t4_rb%0d", e), bus.RB, 1);
      end
    end
    bus.START = 1'b0;
    step();
    check("t4_idle", bus.BUSY, 0);

    // Test 5: reset during SETTLE_B, then a clean scan
    a_val = 1'b1; b_val = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      bus.START = (e == 0);
      step();
    end
    bus.START = 1'b0;
    check("t5_pre_s", bus.S, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t5_rst", outs, 5'b00000);
`ifdef MUX_SCAN_GLITCH_EN
    check("t5_glitch", bus.GLITCH, 0);
`endif
    step();
    check("t5_stay_idle", bus.BUSY, 0);
    for (int e = 0; e <= 10; e++) begin
      bus.START = (e == 0);
      step();
      if (e == 9)  check("t5_edge9", bus.DONE, 0);
      if (e == 10) check("t5_edge10", outs, 5'b10110);
    end
    bus.START = 1'b0;
    step();

    // Test 6: stray START pulses mid-scan are ignored
    a_val = 1'b0; b_val = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      bus.START = (e == 0) || (e == 3) || (e == 7);
      step();
      check($sformatf("t6_done%0d", e), bus.DONE, (e == 10));
      if (e == 10) check("t6_outs", outs, 5'b10101);
      if (e > 10)  check($sformatf("t6_busy%0d", e), bus.BUSY, 0);
    end
    bus.START = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
